core_sequencer: RTL and testbench
=================================

CORE_SEQUENCER -- requirements
Module: core_sequencer

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 16, max consecutive wait cycles on a memory handshake before fault (range 2..255).
REQ-002 SHALL have ports: clk  in  1  sole clock, rising edge.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 run_en  in  1  permits a new fetch; low stalls in FETCH without requesting.
REQ-005 imem_req  out  1 / imem_ready  in  1  instruction-fetch handshake.
REQ-006 ir_we  out  1  load instruction register (one-cycle pulse).
REQ-007 dec_reg_we, dec_mem_we, dec_mem_re, dec_branch, dec_is_system  in  1 each  decoder flags for the current instruction.
REQ-008 dec_pc_sel  in  2  decoder next-PC select (0 = pc+4, 1 = branch/jal, 2 = jalr).
REQ-009 branch_taken  in  1  comparator result, valid in EXEC.
REQ-010 dmem_req  out  1 / dmem_we  out  1 / dmem_ready  in  1  data-memory handshake.
REQ-011 rf_we  out  1  register-file write strobe.
REQ-012 pc_we  out  1 / pc_sel_out  out  2  PC update strobe and resolved select.
REQ-013 retire  out  1  one-cycle pulse per completed instruction.
REQ-014 halted  out  1 / fault  out  1 / state  out  3  status and debug.

Function
REQ-015 States SHALL be FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5, FAULT=6; codes 7 SHALL go to FAULT.
REQ-016 FETCH: imem_req = run_en; on imem_req & imem_ready, ir_we=1 that cycle, next DECODE; ready without req ignored.
REQ-017 DECODE: exactly one cycle, then EXEC; no strobes.
REQ-018 EXEC priority: dec_is_system -> HALT; else dec_mem_re|dec_mem_we -> MEM; else dec_reg_we -> WB; else retire cycle, next FETCH.
REQ-019 MEM: dmem_req=1, dmem_we=dec_mem_we held until dmem_ready; on ready: load -> WB, store -> retire cycle, next FETCH.
REQ-020 WB: rf_we=1 plus retire cycle, next FETCH.
REQ-021 Retire cycle: pc_we=1, retire=1, pc_sel_out = 0 if dec_branch & !branch_taken, else dec_pc_sel; pc_we SHALL be 0 in all other cycles.
REQ-022 Minimum latency: ALU op 4 cycles (FETCH..WB) with zero-wait memory; branch 3; load 5; store 4.
REQ-023 Wait counter SHALL clear on entering FETCH or MEM and increment each cycle req & !ready; after TIMEOUT_CYCLES such consecutive cycles, next state FAULT.
REQ-024 Ready on the final permitted wait cycle SHALL win over timeout.
REQ-025 run_en low SHALL not advance the timeout counter.
REQ-026 HALT and FAULT SHALL be sticky until rst; halted=1 in HALT, fault=1 in FAULT; no requests or strobes there.
REQ-027 Outputs other than status SHALL be combinational from state and inputs; request signals SHALL not drop before ready.

Reset
REQ-028 rst SHALL override all inputs; next state FETCH, wait counter 0.
REQ-029 While rst high all outputs SHALL be 0 (state output reads 0).
REQ-030 rst mid-handshake SHALL abandon the transfer with no rf_we, pc_we or retire.

Structure
REQ-031 State encodings, pc_sel encodings and TIMEOUT_CYCLES default SHALL live in shared package core_pkg.
REQ-032 Wait counter SHALL be sub-module wait_timer (clear, count, expired output).

Verification
REQ-033 ADD, zero-wait memory: imem_ready=1 -> ir_we at cycle 0, rf_we+pc_we+retire at cycle 3, pc_sel_out=0.
REQ-034 BEQ not taken (dec_pc_sel=1, branch_taken=0) -> retire in EXEC, pc_sel_out=0; taken -> pc_sel_out=1; rf_we never 1.
REQ-035 LW with dmem_ready after 3 waits -> dmem_req high 4 cycles, dmem_we=0, then WB rf_we=1; SW same wait -> dmem_we=1, no rf_we.
REQ-036 imem_ready held 0, TIMEOUT_CYCLES=16 -> FAULT entered after 16 wait cycles, fault=1; ready on the 16th wait cycle -> DECODE, no fault.
REQ-037 ECALL (dec_is_system=1) -> HALT, halted=1, no retire; rst pulse -> FETCH.
REQ-038 rst asserted during MEM wait -> all outputs 0 next cycle, no retire, state FETCH.

Source files
------------

// File: rtl/core_pkg.sv
// core_pkg: shared definitions for the instruction sequencer.
//   - state_e             : sequencer state encoding (also exposed on the debug port)
//   - PC_SEL_*            : next-PC select encodings
//   - TIMEOUT_CYCLES_DEFAULT / TIMER_W : memory-handshake timeout default and counter width
//   - resolve_pc_sel()    : resolves the decoder PC select against the branch outcome
package core_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd5,
    ST_FAULT  = 3'd6
  } state_e;

  localparam logic [1:0] PC_SEL_SEQ    = 2'd0;
  localparam logic [1:0] PC_SEL_BRANCH = 2'd1;
  localparam logic [1:0] PC_SEL_JALR   = 2'd2;

  localparam int TIMEOUT_CYCLES_DEFAULT = 16;
  localparam int TIMER_W                = 8;

  // A not-taken conditional branch falls through to pc+4; everything else
  // uses the decoder's select unchanged.
  function automatic logic [1:0] resolve_pc_sel(input logic       branch,
                                                input logic       taken,
                                                input logic [1:0] sel);
    logic [1:0] res;
    if (branch && !taken) begin
      res = PC_SEL_SEQ;
    end else begin
      res = sel;
    end
    return res;
  endfunction

endpackage

// File: rtl/wait_timer.sv
// wait_timer: counts consecutive handshake wait cycles.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   clear     : zero the counter (takes priority over count)
//   count     : this cycle is a wait cycle (request high, ready low)
//   expired   : this wait cycle is the LIMIT-th consecutive one; the owner
//               must leave for its fault state on the next edge
module wait_timer
  import core_pkg::*;
#(
  parameter int LIMIT = TIMEOUT_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic count,
  output logic expired
);

  localparam logic [TIMER_W-1:0] LIMIT_M1 = TIMER_W'(LIMIT - 1);

  logic [TIMER_W-1:0] count_r;

  // Wait-cycle counter; saturates so it can never wrap back below the limit.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_r <= '0;
    end else if (clear) begin
      count_r <= '0;
    end else if (count && (count_r != {TIMER_W{1'b1}})) begin
      count_r <= count_r + TIMER_W'(1);
    end else begin
      count_r <= count_r;
    end
  end

  // count_r holds the number of earlier wait cycles, so a wait cycle seen
  // with LIMIT-1 already behind it is the last one permitted. A ready in
  // that same cycle means count is low, so ready wins over the timeout.
  assign expired = count && (count_r >= LIMIT_M1);

endmodule

// File: rtl/core_sequencer.sv
// core_sequencer: multi-cycle control FSM for a simple RISC core.
// Sequence: FETCH -> DECODE -> EXEC -> [MEM] -> [WB] -> FETCH, with sticky
// HALT (system instruction) and FAULT (handshake timeout / illegal state).
// Ports:
//   clk, rst                     : clock, synchronous active-high reset
//   run_en                       : permits a new instruction fetch
//   imem_req / imem_ready        : instruction-fetch handshake
//   ir_we                        : instruction-register load pulse
//   dec_*                        : decoder flags for the current instruction
//   branch_taken                 : comparator result, valid in EXEC
//   dmem_req / dmem_we / dmem_ready : data-memory handshake
//   rf_we                        : register-file write strobe
//   pc_we / pc_sel_out           : PC update strobe and resolved select
//   retire                       : one pulse per completed instruction
//   halted / fault / state       : status and debug
module core_sequencer
  import core_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run_en,
  output logic       imem_req,
  input  logic       imem_ready,
  output logic       ir_we,
  input  logic       dec_reg_we,
  input  logic       dec_mem_we,
  input  logic       dec_mem_re,
  input  logic       dec_branch,
  input  logic       dec_is_system,
  input  logic [1:0] dec_pc_sel,
  input  logic       branch_taken,
  output logic       dmem_req,
  output logic       dmem_we,
  input  logic       dmem_ready,
  output logic       rf_we,
  output logic       pc_we,
  output logic [1:0] pc_sel_out,
  output logic       retire,
  output logic       halted,
  output logic       fault,
  output logic [2:0] state
);

  state_e     state_r;
  state_e     state_next_s;
  logic       imem_req_s;
  logic       ir_we_s;
  logic       dmem_req_s;
  logic       dmem_we_s;
  logic       rf_we_s;
  logic       pc_we_s;
  logic [1:0] pc_sel_s;
  logic       retire_s;
  logic       timer_count_s;
  logic       timer_clear_s;
  logic       timer_expired_s;

  // Every state change clears the timer, which covers entry to FETCH and MEM.
  assign timer_clear_s = (state_next_s != state_r);

  wait_timer #(
    .LIMIT(TIMEOUT_CYCLES)
  ) u_wait_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (timer_clear_s),
    .count  (timer_count_s),
    .expired(timer_expired_s)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_FETCH;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state, handshake and strobe decode.
  always_comb begin
    state_next_s  = state_r;
    imem_req_s    = 1'b0;
    ir_we_s       = 1'b0;
    dmem_req_s    = 1'b0;
    dmem_we_s     = 1'b0;
    rf_we_s       = 1'b0;
    pc_we_s       = 1'b0;
    pc_sel_s      = PC_SEL_SEQ;
    retire_s      = 1'b0;
    timer_count_s = 1'b0;

    case (state_r)
      ST_FETCH: begin
        // With run_en low there is no request, so neither ready nor the
        // timer can advance the fetch.
        imem_req_s    = run_en;
        timer_count_s = run_en & ~imem_ready;
        if (run_en && imem_ready) begin
          ir_we_s      = 1'b1;
          state_next_s = ST_DECODE;
        end else if (timer_expired_s) begin
          state_next_s = ST_FAULT;
        end else begin
          state_next_s = ST_FETCH;
        end
      end
      ST_DECODE: begin
        state_next_s = ST_EXEC;
      end
      ST_EXEC: begin
        if (dec_is_system) begin
          state_next_s = ST_HALT;
        end else if (dec_mem_re || dec_mem_we) begin
          state_next_s = ST_MEM;
        end else if (dec_reg_we) begin
          state_next_s = ST_WB;
        end else begin
          retire_s     = 1'b1;
          state_next_s = ST_FETCH;
        end
      end
      ST_MEM: begin
        // Request stays up until ready; a write flag marks a store.
        dmem_req_s    = 1'b1;
        dmem_we_s     = dec_mem_we;
        timer_count_s = ~dmem_ready;
        if (dmem_ready) begin
          if (dec_mem_we) begin
            retire_s     = 1'b1;
            state_next_s = ST_FETCH;
          end else begin
            state_next_s = ST_WB;
          end
        end else if (timer_expired_s) begin
          state_next_s = ST_FAULT;
        end else begin
          state_next_s = ST_MEM;
        end
      end
      ST_WB: begin
        rf_we_s      = 1'b1;
        retire_s     = 1'b1;
        state_next_s = ST_FETCH;
      end
      ST_HALT: begin
        state_next_s = ST_HALT;
      end
      ST_FAULT: begin
        state_next_s = ST_FAULT;
      end
      default: begin
        // Unused encoding: treat as corruption.
        state_next_s = ST_FAULT;
      end
    endcase

    // The retire cycle is the only cycle that updates the PC.
    if (retire_s) begin
      pc_we_s  = 1'b1;
      pc_sel_s = resolve_pc_sel(dec_branch, branch_taken, dec_pc_sel);
    end else begin
      pc_we_s  = 1'b0;
      pc_sel_s = PC_SEL_SEQ;
    end

    // Reset overrides everything, abandoning any transfer in flight.
    if (rst) begin
      state_next_s  = ST_FETCH;
      imem_req_s    = 1'b0;
      ir_we_s       = 1'b0;
      dmem_req_s    = 1'b0;
      dmem_we_s     = 1'b0;
      rf_we_s       = 1'b0;
      pc_we_s       = 1'b0;
      pc_sel_s      = PC_SEL_SEQ;
      retire_s      = 1'b0;
      timer_count_s = 1'b0;
    end else begin
      state_next_s  = state_next_s;
    end
  end

  assign imem_req   = imem_req_s;
  assign ir_we      = ir_we_s;
  assign dmem_req   = dmem_req_s;
  assign dmem_we    = dmem_we_s;
  assign rf_we      = rf_we_s;
  assign pc_we      = pc_we_s;
  assign pc_sel_out = pc_sel_s;
  assign retire     = retire_s;

  // Status comes straight from the state register, masked while in reset.
  assign halted = ~rst & (state_r == ST_HALT);
  assign fault  = ~rst & (state_r == ST_FAULT);
  assign state  = rst ? 3'd0 : state_r;

endmodule

// File: tb/tb_core_sequencer.sv
// Bench for core_sequencer: a transaction-level model expands each directed
// instruction (decoder flags plus memory wait counts) into the per-cycle
// inputs and expected outputs; one process drives and compares every cycle,
// then per-instruction latencies and status counts are pinned by literals.
module tb_core_sequencer;

  localparam int TMO = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       run_en;
  logic       imem_req;
  logic       imem_ready;
  logic       ir_we;
  logic       dec_reg_we;
  logic       dec_mem_we;
  logic       dec_mem_re;
  logic       dec_branch;
  logic       dec_is_system;
  logic [1:0] dec_pc_sel;
  logic       branch_taken;
  logic       dmem_req;
  logic       dmem_we;
  logic       dmem_ready;
  logic       rf_we;
  logic       pc_we;
  logic [1:0] pc_sel_out;
  logic       retire;
  logic       halted;
  logic       fault;
  logic [2:0] state;

  always #5 clk = ~clk;

  core_sequencer #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst), .run_en(run_en),
    .imem_req(imem_req), .imem_ready(imem_ready), .ir_we(ir_we),
    .dec_reg_we(dec_reg_we), .dec_mem_we(dec_mem_we), .dec_mem_re(dec_mem_re),
    .dec_branch(dec_branch), .dec_is_system(dec_is_system), .dec_pc_sel(dec_pc_sel),
    .branch_taken(branch_taken),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ready(dmem_ready),
    .rf_we(rf_we), .pc_we(pc_we), .pc_sel_out(pc_sel_out), .retire(retire),
    .halted(halted), .fault(fault), .state(state)
  );

  typedef struct {
    logic       rst, run_en, imem_ready, dmem_ready;
    logic       reg_we, mem_we, mem_re, branch, sys, taken;
    logic [1:0] pcsel;
    logic       e_imem_req, e_ir_we, e_dmem_req, e_dmem_we, e_rf_we;
    logic       e_pc_we, e_retire, e_halted, e_fault;
    logic [1:0] e_sel;
    logic [2:0] e_st;
  } cyc_t;

  cyc_t cur;
  cyc_t q[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Fresh cycle: current instruction flags, run enabled, no ready, no outputs.
  function automatic cyc_t base();
    cyc_t c = cur;
    c.rst = 1'b0; c.run_en = 1'b1; c.imem_ready = 1'b0; c.dmem_ready = 1'b0;
    c.e_imem_req = 1'b0; c.e_ir_we = 1'b0; c.e_dmem_req = 1'b0; c.e_dmem_we = 1'b0;
    c.e_rf_we = 1'b0; c.e_pc_we = 1'b0; c.e_retire = 1'b0; c.e_halted = 1'b0;
    c.e_fault = 1'b0; c.e_sel = 2'd0; c.e_st = 3'd0;
    return c;
  endfunction

  // Completion: PC written; a not-taken branch falls through to pc+4.
  task automatic set_retire(inout cyc_t c);
    c.e_retire = 1'b1;
    c.e_pc_we  = 1'b1;
    c.e_sel    = (c.branch && !c.taken) ? 2'd0 : c.pcsel;
  endtask

  task automatic push_reset();
    cyc_t c = base();
    c.rst = 1'b1; c.imem_ready = 1'b1; c.dmem_ready = 1'b1;
    q.push_back(c);
  endtask

  // HALT (5) or FAULT (6) for n cycles with every ready offered, then reset.
  task automatic push_sticky(input logic [2:0] st, input int n);
    cyc_t c;
    for (int k = 0; k < n; k++) begin
      c = base();
      c.imem_ready = 1'b1; c.dmem_ready = 1'b1; c.e_st = st;
      if (st == 3'd6) c.e_fault = 1'b1; else c.e_halted = 1'b1;
      q.push_back(c);
    end
    push_reset();
  endtask

  task automatic gen_instr(input logic reg_we, mem_we, mem_re, branch, sys, taken,
                           input logic [1:0] pcsel, input int iw, stall_at, stall_len,
                           input int dw, abort_at);
    cyc_t c;
    int   waits;
    cur.reg_we = reg_we; cur.mem_we = mem_we; cur.mem_re = mem_re;
    cur.branch = branch; cur.sys = sys; cur.taken = taken; cur.pcsel = pcsel;
    // fetch: iw wait cycles, optional run_en stall (ready offered, must be ignored)
    waits = 0;
    for (int i = 0; i < iw; i++) begin
      if (i == stall_at) begin
        for (int s = 0; s < stall_len; s++) begin
          c = base(); c.run_en = 1'b0; c.imem_ready = 1'b1; q.push_back(c);
        end
      end
      c = base(); c.e_imem_req = 1'b1; q.push_back(c);
      waits++;
      if (waits == TMO) begin push_sticky(3'd6, 3); return; end
    end
    c = base(); c.imem_ready = 1'b1; c.e_imem_req = 1'b1; c.e_ir_we = 1'b1; q.push_back(c);
    c = base(); c.e_st = 3'd1; q.push_back(c);
    c = base(); c.e_st = 3'd2;
    if (sys) begin
      q.push_back(c); push_sticky(3'd5, 4); return;
    end else if (!(mem_re || mem_we)) begin
      if (!reg_we) set_retire(c);
      q.push_back(c);
    end else begin
      q.push_back(c);
      waits = 0;
      for (int i = 0; i < dw; i++) begin
        if (i == abort_at) begin push_reset(); return; end
        c = base(); c.e_st = 3'd3; c.e_dmem_req = 1'b1; c.e_dmem_we = mem_we; q.push_back(c);
        waits++;
        if (waits == TMO) begin push_sticky(3'd6, 3); return; end
      end
      c = base(); c.e_st = 3'd3; c.dmem_ready = 1'b1;
      c.e_dmem_req = 1'b1; c.e_dmem_we = mem_we;
      if (mem_we) set_retire(c);
      q.push_back(c);
      if (mem_we) return;
    end
    if (reg_we) begin
      c = base(); c.e_st = 3'd4; c.e_rf_we = 1'b1; set_retire(c); q.push_back(c);
    end
  endtask

  int exp_lat [10] = '{3, 2, 2, 3, 7, 6, 4, 3, 3, 3};
  int exp_dm  [10] = '{0, 0, 0, 0, 4, 4, 1, 0, 0, 0};
  int exp_sel [10] = '{0, 0, 1, 2, 0, 0, 0, 0, 0, 0};

  initial begin
    int lat_q[$];
    int dm_q[$];
    int sel_q[$];
    int mark, dm_cnt, halt_cnt, fault_cnt;
    logic [13:0] act_v, exp_v;
    cur = '{default: '0};
    mark = 0; dm_cnt = 0; halt_cnt = 0; fault_cnt = 0;

    push_reset(); push_reset();
    //        reg mw  mr  br  sys tk  sel  iw  st_at st_len dw abort
    gen_instr(1, 0, 0, 0, 0, 0, 2'd0, 0,  -1, 0,  0, -1);  // ADD
    gen_instr(0, 0, 0, 1, 0, 0, 2'd1, 0,  -1, 0,  0, -1);  // BEQ not taken
    gen_instr(0, 0, 0, 1, 0, 1, 2'd1, 0,  -1, 0,  0, -1);  // BEQ taken
    gen_instr(1, 0, 0, 0, 0, 0, 2'd2, 0,  -1, 0,  0, -1);  // JALR
    gen_instr(1, 0, 1, 0, 0, 0, 2'd0, 0,  -1, 0,  3, -1);  // LW, 3 waits
    gen_instr(0, 1, 0, 0, 0, 0, 2'd0, 0,  -1, 0,  3, -1);  // SW, 3 waits
    gen_instr(1, 0, 1, 0, 0, 0, 2'd0, 2,  -1, 0,  0, -1);  // LW, fetch waits
    gen_instr(1, 0, 0, 0, 0, 0, 2'd0, 15, 10, 8,  0, -1);  // ADD, stall mid-wait
    gen_instr(1, 0, 0, 0, 0, 0, 2'd0, 15, -1, 0,  0, -1);  // ready on final wait
    gen_instr(1, 0, 0, 0, 0, 0, 2'd0, 16, -1, 0,  0, -1);  // fetch timeout
    gen_instr(0, 0, 0, 0, 1, 0, 2'd0, 0,  -1, 0,  0, -1);  // ECALL
    gen_instr(1, 0, 1, 0, 0, 0, 2'd0, 0,  -1, 0,  5,  2);  // LW aborted by rst
    gen_instr(0, 1, 0, 0, 0, 0, 2'd0, 0,  -1, 0, 16, -1);  // SW data timeout
    gen_instr(1, 0, 0, 0, 0, 0, 2'd0, 0,  -1, 0,  0, -1);  // ADD after recovery

    for (int i = 0; i < q.size(); i++) begin
      rst = q[i].rst; run_en = q[i].run_en;
      imem_ready = q[i].imem_ready; dmem_ready = q[i].dmem_ready;
      dec_reg_we = q[i].reg_we; dec_mem_we = q[i].mem_we; dec_mem_re = q[i].mem_re;
      dec_branch = q[i].branch; dec_is_system = q[i].sys;
      dec_pc_sel = q[i].pcsel; branch_taken = q[i].taken;
      @(negedge clk);
      act_v = {imem_req, ir_we, dmem_req, dmem_we, rf_we, pc_we, retire,
               halted, fault, pc_sel_out, state};
      exp_v = {q[i].e_imem_req, q[i].e_ir_we, q[i].e_dmem_req, q[i].e_dmem_we,
               q[i].e_rf_we, q[i].e_pc_we, q[i].e_retire, q[i].e_halted,
               q[i].e_fault, q[i].e_sel, q[i].e_st};
      check($sformatf("cycle%0d outputs", i), 32'(act_v), 32'(exp_v));
      if (ir_we) begin mark = i; dm_cnt = 0; end
      if (dmem_req) dm_cnt++;
      if (halted) halt_cnt++;
      if (fault) fault_cnt++;
      if (retire) begin
        lat_q.push_back(i - mark); dm_q.push_back(dm_cnt); sel_q.push_back(int'(pc_sel_out));
      end
      @(posedge clk);
      #1;
    end

    check("retire_count", 32'(lat_q.size()), 32'd10);
    for (int k = 0; k < 10; k++) begin
      if (k < lat_q.size()) begin
        check($sformatf("latency%0d", k), 32'(lat_q[k]), 32'(exp_lat[k]));
        check($sformatf("dmem_req_cycles%0d", k), 32'(dm_q[k]), 32'(exp_dm[k]));
        check($sformatf("pc_sel%0d", k), 32'(sel_q[k]), 32'(exp_sel[k]));
      end else begin
        check($sformatf("latency%0d_missing", k), 32'd0, 32'd1);
      end
    end
    check("halted_cycles", 32'(halt_cnt), 32'd4);
    check("fault_cycles", 32'(fault_cnt), 32'd6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
